// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit
// and the instruction memory (master = fetch unit, slave = memory).
interface if_fetch_unit_if;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Ready;
  logic [31:0] IMEM_Data;

  modport master (
    output IMEM_Req,
    output IMEM_Addr,
    input  IMEM_Ready,
    input  IMEM_Data
  );

  modport slave (
    input  IMEM_Req,
    input  IMEM_Addr,
    output IMEM_Ready,
    output IMEM_Data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the PC, issues instruction-memory
// requests, absorbs IF stalls in a 1-entry skid and drops wrong-path words.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          TIMEOUT  = 16
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           PCWrite,
  input  logic           Branch,
  input  logic [1:0]     Jump,
  input  logic [31:0]    BTB_Addr,
  input  logic [31:0]    Jump_Addr,
  input  logic [31:0]    JR_Addr,
  if_fetch_unit_if.master imem,
  output logic [31:0]    IF_Instruction,
  output logic [31:0]    IF_PC_4,
  output logic           IF_Valid,
  output logic           Fetch_Err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   drop_q, drop_d;
  logic [31:0]   skid_q, skid_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;

  logic          req;
  logic          accept;
  logic          redirect;
  logic [31:0]   target;
  logic [31:0]   pc_4;
  logic [31:0]   next_pc;

  // Redirect decode: JR beats J/JAL beats a taken branch; stalls gate it.
  always_comb begin
    target = BTB_Addr;
    unique case (1'b1)
      (Jump == 2'b10): target = JR_Addr;
      (Jump == 2'b01): target = Jump_Addr;
      default:         target = BTB_Addr;
    endcase
    redirect = PCWrite &
               (Branch | (Jump == 2'b01) | (Jump == 2'b10));
    pc_4     = pc_q + 32'd4;
    next_pc  = redirect ? target : pc_4;
  end

  // Request port and presented-instruction outputs.
  always_comb begin
    req            = (state_q == FETCH) | (state_q == DROP);
    accept         = (state_q == FETCH) & imem.IMEM_Ready;
    imem.IMEM_Req  = req;
    imem.IMEM_Addr = (state_q == DROP) ? drop_q : pc_q;
    IF_PC_4        = pc_4;
    IF_Valid       = accept | (state_q == HOLD);
    IF_Instruction = 32'd0;
    if (accept)
      IF_Instruction = imem.IMEM_Data;
    else if (state_q == HOLD)
      IF_Instruction = skid_q;
    Fetch_Err      = err_q;
  end

  // Next-state logic for PC, FSM, skid and wrong-path address.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    skid_d  = skid_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (accept) begin
          if (PCWrite) begin
            pc_d = next_pc;
          end else begin
            skid_d  = imem.IMEM_Data;
            state_d = HOLD;
          end
        end else if (redirect) begin
          drop_d  = pc_q;
          pc_d    = target;
          state_d = DROP;
        end
      end
      DROP: begin
        if (redirect)
          pc_d = target;
        if (imem.IMEM_Ready)
          state_d = FETCH;
      end
      HOLD: begin
        if (PCWrite) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait-cycle counter over any outstanding request; sticky error flag.
  always_comb begin
    wcnt_d = wcnt_q;
    err_d  = err_q;
    if (req) begin
      if (imem.IMEM_Ready)
        wcnt_d = '0;
      else if (wcnt_q != TMAX)
        wcnt_d = wcnt_q + 1'b1;
    end
    if (wcnt_d == TMAX)
      err_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 32'd0;
      skid_q  <= 32'd0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      skid_q  <= skid_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

endmodule
